// File: rtl/bcd_time_entry_pkg.sv
// ============================================================================
// bcd_time_entry_pkg : shared states, phase selects and BCD limits
// Rev 1.0
// ============================================================================
`default_nettype none

package bcd_time_entry_pkg;

  typedef enum logic [2:0] {
    ST_IDLE         = 3'd0,
    ST_WAIT_TENS    = 3'd1,
    ST_WAIT_ONES    = 3'd2,
    ST_WAIT_CONFIRM = 3'd3,
    ST_CONVERT      = 3'd4,
    ST_CHECK        = 3'd5,
    ST_LOAD         = 3'd6,
    ST_ERROR        = 3'd7
  } state_e;

  localparam logic [1:0] SEL_RED    = 2'd0;
  localparam logic [1:0] SEL_YELLOW = 2'd1;
  localparam logic [1:0] SEL_GREEN  = 2'd2;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Phase rotation red -> yellow -> green -> red; code 3 is never produced.
  function automatic logic [1:0] next_sel(input logic [1:0] cur);
    case (cur)
      SEL_RED:    return SEL_YELLOW;
      SEL_YELLOW: return SEL_GREEN;
      default:    return SEL_RED;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_time_entry_if.sv
// ============================================================================
// bcd_time_entry_if : key inputs and time-register write port of the entry block
// Rev 1.0
// ============================================================================
`default_nettype none

interface bcd_time_entry_if #(
  parameter int TIME_W = 7
) ();

  logic              set_mode;
  logic [3:0]        digit_in;
  logic              key_digit;
  logic              key_enter;
  logic              key_clear;
  logic [TIME_W-1:0] time_out;
  logic [1:0]        sel;
  logic              load;
  logic [3:0]        echo_d1;
  logic [3:0]        echo_d0;
  logic              err;
  logic              busy;

  modport master (
    output set_mode, digit_in, key_digit, key_enter, key_clear,
    input  time_out, sel, load, echo_d1, echo_d0, err, busy
  );

  modport slave (
    input  set_mode, digit_in, key_digit, key_enter, key_clear,
    output time_out, sel, load, echo_d1, echo_d0, err, busy
  );

endinterface

`default_nettype wire

// File: rtl/bcd_time_entry_key_edge.sv
// ============================================================================
// bcd_time_entry_key_edge : one-flop history rising-edge detector for a key
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_time_entry_key_edge (
  input  wire  clk,
  input  wire  reset,
  input  wire  key,
  output logic key_rise
);

  logic key_q;
  logic key_d;

  assign key_d = key;

  always_ff @(posedge clk) begin
    if (reset) begin
      key_q <= 1'b0;
    end else begin
      key_q <= key_d;
    end
  end

  // Fires in the cycle the key is first seen high, so the FSM reacts on that edge.
  assign key_rise = key & ~key_q;

endmodule

`default_nettype wire

// File: rtl/bcd_time_entry.sv
// ============================================================================
// bcd_time_entry : two-digit BCD entry, serial BCD->binary, range check, phase load
// Rev 1.0
// ============================================================================
`default_nettype none

module bcd_time_entry
  import bcd_time_entry_pkg::*;
#(
  parameter int TIME_W   = 7,
  parameter int MIN_TIME = 1,
  parameter int MAX_TIME = 99
) (
  input  wire              clk,
  input  wire              reset,
  bcd_time_entry_if.slave  bus
);

  logic digit_ev;
  logic enter_ev;
  logic clear_ev;

  bcd_time_entry_key_edge u_edge_digit (.clk(clk), .reset(reset), .key(bus.key_digit), .key_rise(digit_ev));
  bcd_time_entry_key_edge u_edge_enter (.clk(clk), .reset(reset), .key(bus.key_enter), .key_rise(enter_ev));
  bcd_time_entry_key_edge u_edge_clear (.clk(clk), .reset(reset), .key(bus.key_clear), .key_rise(clear_ev));

  state_e            state_q,    state_d;
  logic [3:0]        tens_q,     tens_d;
  logic [3:0]        ones_q,     ones_d;
  logic [3:0]        cnt_q,      cnt_d;
  logic [6:0]        acc_q,      acc_d;
  logic [TIME_W-1:0] time_out_q, time_out_d;
  logic [1:0]        sel_q,      sel_d;
  logic              load_q,     load_d;
  logic              err_q,      err_d;
  logic              busy_q,     busy_d;
  logic [3:0]        echo_d1_q,  echo_d1_d;
  logic [3:0]        echo_d0_q,  echo_d0_d;

  always_comb begin
    state_d    = state_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    time_out_d = time_out_q;
    sel_d      = sel_q;
    echo_d1_d  = echo_d1_q;
    echo_d0_d  = echo_d0_q;

    case (state_q)
      // IDLE is only ever occupied while set_mode is low (or straight after
      // reset), so seeing it high here is the set_mode rising edge.
      ST_IDLE: begin
        if (bus.set_mode) begin
          state_d   = ST_WAIT_TENS;
          sel_d     = SEL_RED;
          echo_d1_d = 4'd0;
          echo_d0_d = 4'd0;
        end
      end
      ST_WAIT_TENS: begin
        if (clear_ev) begin
          echo_d1_d = 4'd0;
          echo_d0_d = 4'd0;
        end else if (digit_ev) begin
          if (bus.digit_in > BCD_MAX) begin
            state_d = ST_ERROR;
          end else begin
            tens_d    = bus.digit_in;
            echo_d1_d = bus.digit_in;
            state_d   = ST_WAIT_ONES;
          end
        end
      end
      ST_WAIT_ONES: begin
        if (clear_ev) begin
          echo_d1_d = 4'd0;
          echo_d0_d = 4'd0;
          state_d   = ST_WAIT_TENS;
        end else if (enter_ev) begin
          // Single digit: the digit already captured is really the ones digit.
          ones_d    = tens_q;
          tens_d    = 4'd0;
          echo_d1_d = 4'd0;
          echo_d0_d = tens_q;
          acc_d     = {3'd0, tens_q};
          cnt_d     = 4'd0;
          state_d   = ST_CONVERT;
        end else if (digit_ev) begin
          if (bus.digit_in > BCD_MAX) begin
            state_d = ST_ERROR;
          end else begin
            ones_d    = bus.digit_in;
            echo_d0_d = bus.digit_in;
            state_d   = ST_WAIT_CONFIRM;
          end
        end
      end
      ST_WAIT_CONFIRM: begin
        if (clear_ev) begin
          echo_d1_d = 4'd0;
          echo_d0_d = 4'd0;
          state_d   = ST_WAIT_TENS;
        end else if (enter_ev) begin
          acc_d   = {3'd0, ones_q};
          cnt_d   = tens_q;
          state_d = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_CHECK;
        end else begin
          acc_d = acc_q + 7'd10;
          cnt_d = cnt_q - 4'd1;
        end
      end
      ST_CHECK: begin
        if ((int'(acc_q) >= MIN_TIME) && (int'(acc_q) <= MAX_TIME)) begin
          time_out_d = TIME_W'(acc_q);
          state_d    = ST_LOAD;
        end else begin
          state_d = ST_ERROR;
        end
      end
      ST_LOAD: begin
        sel_d     = next_sel(sel_q);
        echo_d1_d = 4'd0;
        echo_d0_d = 4'd0;
        state_d   = ST_WAIT_TENS;
      end
      ST_ERROR: begin
        if (clear_ev) begin
          echo_d1_d = 4'd0;
          echo_d0_d = 4'd0;
          state_d   = ST_WAIT_TENS;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Leaving set mode abandons whatever is in flight, including a pending load.
    if (!bus.set_mode) begin
      state_d   = ST_IDLE;
      echo_d1_d = 4'd0;
      echo_d0_d = 4'd0;
    end

    load_d = (state_d == ST_LOAD);
    err_d  = (state_d == ST_ERROR);
    busy_d = (state_d inside {ST_CONVERT, ST_CHECK, ST_LOAD});
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      tens_q     <= 4'd0;
      ones_q     <= 4'd0;
      cnt_q      <= 4'd0;
      acc_q      <= 7'd0;
      time_out_q <= '0;
      sel_q      <= SEL_RED;
      load_q     <= 1'b0;
      err_q      <= 1'b0;
      busy_q     <= 1'b0;
      echo_d1_q  <= 4'd0;
      echo_d0_q  <= 4'd0;
    end else begin
      state_q    <= state_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      time_out_q <= time_out_d;
      sel_q      <= sel_d;
      load_q     <= load_d;
      err_q      <= err_d;
      busy_q     <= busy_d;
      echo_d1_q  <= echo_d1_d;
      echo_d0_q  <= echo_d0_d;
    end
  end

  assign bus.time_out = time_out_q;
  assign bus.sel      = sel_q;
  assign bus.load     = load_q;
  assign bus.err      = err_q;
  assign bus.busy     = busy_q;
  assign bus.echo_d1  = echo_d1_q;
  assign bus.echo_d0  = echo_d0_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_time_entry.sv
// ============================================================================
// tb_bcd_time_entry : directed self-checking bench for bcd_time_entry
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bcd_time_entry;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  bcd_time_entry_if #(.TIME_W(7)) bus ();

  bcd_time_entry #(.TIME_W(7), .MIN_TIME(1), .MAX_TIME(99)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    bus.digit_in  = d;
    bus.key_digit = 1'b1;
    tick();
    bus.key_digit = 1'b0;
    tick();
  endtask

  task automatic press_clear();
    bus.key_clear = 1'b1;
    tick();
    bus.key_clear = 1'b0;
    tick();
  endtask

  task automatic restart();
    bus.set_mode = 1'b0;
    tick();
    tick();
    bus.set_mode = 1'b1;
    tick();
  endtask

  // Presses enter (cycle E) and watches 20 cycles; k counts cycles after E.
  task automatic enter_and_wait(output int lc, output int cnt, output logic [6:0] t,
                                output logic [1:0] s, output logic [3:0] e1, output logic [3:0] e0);
    lc = -1; cnt = 0; t = '0; s = '0; e1 = '0; e0 = '0;
    bus.key_enter = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      bus.key_enter = 1'b0;
      if (k == 1) begin e1 = bus.echo_d1; e0 = bus.echo_d0; end
      if (bus.load) begin
        cnt++;
        if (lc < 0) begin lc = k; t = bus.time_out; s = bus.sel; end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.set_mode = 1'b1; bus.digit_in = 4'd0;
    bus.key_digit = 1'b0; bus.key_enter = 1'b0; bus.key_clear = 1'b0;
    repeat (3) tick();
    checks++; if (bus.load !== 1'b0) begin errors++; $display("FAIL reset_load: got %0d exp 0", bus.load); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0d exp 0", bus.err); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0d exp 0", bus.busy); end
    checks++; if ({bus.sel, bus.time_out, bus.echo_d1, bus.echo_d0} !== 17'd0) begin errors++;
      $display("FAIL reset_outputs: got %h exp 0", {bus.sel, bus.time_out, bus.echo_d1, bus.echo_d0}); end
    bus.set_mode = 1'b0;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_two_digit();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd4);
    checks++; if (bus.echo_d1 !== 4'd4) begin errors++; $display("FAIL two_echo_d1: got %0d exp 4", bus.echo_d1); end
    press_digit(4'd5);
    checks++; if (bus.echo_d0 !== 4'd5) begin errors++; $display("FAIL two_echo_d0: got %0d exp 5", bus.echo_d0); end
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if (lc !== 7) begin errors++; $display("FAIL two_latency: got %0d exp 7", lc); end
    checks++; if (cnt !== 1) begin errors++; $display("FAIL two_load_count: got %0d exp 1", cnt); end
    checks++; if (t !== 7'd45) begin errors++; $display("FAIL two_time: got %0d exp 45", t); end
    checks++; if (s !== 2'd0) begin errors++; $display("FAIL two_sel: got %0d exp 0", s); end
    checks++; if (bus.sel !== 2'd1) begin errors++; $display("FAIL two_sel_after: got %0d exp 1", bus.sel); end
    checks++; if ({bus.echo_d1, bus.echo_d0} !== 8'h00) begin errors++;
      $display("FAIL two_echo_cleared: got %h exp 00", {bus.echo_d1, bus.echo_d0}); end
    checks++; if (bus.time_out !== 7'd45) begin errors++; $display("FAIL two_time_held: got %0d exp 45", bus.time_out); end
  endtask

  task automatic test_single_digit();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd7);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if (lc !== 3) begin errors++; $display("FAIL single_latency: got %0d exp 3", lc); end
    checks++; if (t !== 7'd7) begin errors++; $display("FAIL single_time: got %0d exp 7", t); end
    checks++; if (e1 !== 4'd0) begin errors++; $display("FAIL single_echo_d1: got %0d exp 0", e1); end
    checks++; if (e0 !== 4'd7) begin errors++; $display("FAIL single_echo_d0: got %0d exp 7", e0); end
  endtask

  task automatic test_back_to_back();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd3); press_digit(4'd0);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t, s} !== {32'd6, 7'd30, 2'd0}) begin errors++;
      $display("FAIL seq30: got lat %0d time %0d sel %0d exp 6 30 0", lc, t, s); end
    press_digit(4'd4);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t, s} !== {32'd3, 7'd4, 2'd1}) begin errors++;
      $display("FAIL seq4: got lat %0d time %0d sel %0d exp 3 4 1", lc, t, s); end
    press_digit(4'd2); press_digit(4'd5);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t, s} !== {32'd5, 7'd25, 2'd2}) begin errors++;
      $display("FAIL seq25: got lat %0d time %0d sel %0d exp 5 25 2", lc, t, s); end
    press_digit(4'd9); press_digit(4'd9);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t, s} !== {32'd12, 7'd99, 2'd0}) begin errors++;
      $display("FAIL seq99: got lat %0d time %0d sel %0d exp 12 99 0", lc, t, s); end
  endtask

  task automatic test_range_error();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd5);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    press_digit(4'd0); press_digit(4'd0);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if (cnt !== 0) begin errors++; $display("FAIL zero_load_count: got %0d exp 0", cnt); end
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL zero_err: got %0d exp 1", bus.err); end
    press_clear();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL zero_err_cleared: got %0d exp 0", bus.err); end
    checks++; if (bus.sel !== 2'd1) begin errors++; $display("FAIL zero_sel_kept: got %0d exp 1", bus.sel); end
    press_digit(4'd6);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t, s} !== {32'd3, 7'd6, 2'd1}) begin errors++;
      $display("FAIL zero_recover: got lat %0d time %0d sel %0d exp 3 6 1", lc, t, s); end
  endtask

  task automatic test_bad_digit_and_hold();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd12);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_tens_err: got %0d exp 1", bus.err); end
    press_clear();
    press_digit(4'd1); press_digit(4'd10);
    checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL bad_ones_err: got %0d exp 1", bus.err); end
    press_clear();
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL bad_cleared: got %0d exp 0", bus.err); end
    bus.digit_in  = 4'd3;
    bus.key_digit = 1'b1;
    repeat (20) tick();
    bus.key_digit = 1'b0;
    tick();
    checks++; if ({bus.echo_d1, bus.echo_d0} !== 8'h30) begin errors++;
      $display("FAIL hold_echo: got %h exp 30", {bus.echo_d1, bus.echo_d0}); end
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t} !== {32'd3, 7'd3}) begin errors++;
      $display("FAIL hold_single_event: got lat %0d time %0d exp 3 3", lc, t); end
  endtask

  task automatic test_abort_convert();
    int loads = 0;
    restart();
    press_digit(4'd9); press_digit(4'd9);
    bus.key_enter = 1'b1;
    tick();
    bus.key_enter = 1'b0;
    checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL abort_busy_convert: got %0d exp 1", bus.busy); end
    tick();
    bus.set_mode = 1'b0;
    tick();
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0d exp 0", bus.busy); end
    for (int k = 0; k < 15; k++) begin
      if (bus.load) loads++;
      tick();
    end
    checks++; if (loads !== 0) begin errors++; $display("FAIL abort_no_load: got %0d exp 0", loads); end
    checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL abort_err: got %0d exp 0", bus.err); end
  endtask

  task automatic test_clear_priority();
    int lc, cnt; logic [6:0] t; logic [1:0] s; logic [3:0] e1, e0;
    restart();
    press_digit(4'd2);
    bus.digit_in  = 4'd5;
    bus.key_digit = 1'b1;
    bus.key_clear = 1'b1;
    tick();
    bus.key_digit = 1'b0;
    bus.key_clear = 1'b0;
    tick();
    checks++; if ({bus.echo_d1, bus.echo_d0} !== 8'h00) begin errors++;
      $display("FAIL prio_echo: got %h exp 00", {bus.echo_d1, bus.echo_d0}); end
    press_digit(4'd8);
    enter_and_wait(lc, cnt, t, s, e1, e0);
    checks++; if ({lc, t} !== {32'd3, 7'd8}) begin errors++;
      $display("FAIL prio_discard: got lat %0d time %0d exp 3 8", lc, t); end
  endtask

  initial begin
    test_reset();
    test_two_digit();
    test_single_digit();
    test_back_to_back();
    test_range_error();
    test_bad_digit_and_hold();
    test_abort_convert();
    test_clear_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
